// File: rtl/ram32m_hist_ctrl_pkg.sv
// Shared types and default widths for the histogram RAM sequencer.
package hist_pkg;

    localparam int WIDTH_DEF     = 8;
    localparam int ADDRWIDTH_DEF = 5;
    localparam int CNT_W_DEF     = 16;
    localparam int FLUSH_CYCLES  = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/ram32m_hist_ctrl.sv
// Sequencer for a read-increment-write counter RAM: hazard-spaced bin
// increments, then a full sweep streamed out as a dump.
//
// state | meaning
// IDLE  | waiting for start (ignored while the final dump beat is pending)
// ACCUM | accepting bins; same-address back-to-back gets one bubble
// FLUSH | one quiet cycle so the last write commits
// DRAIN | sweep all addresses; dump beats trail by one cycle
module ram32m_hist_ctrl
    import hist_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int ADDRWIDTH = ADDRWIDTH_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_W-1:0]     nsamp,
    input  logic                 bin_valid,
    output logic                 bin_ready,
    input  logic [ADDRWIDTH-1:0] bin_addr,
    output logic [ADDRWIDTH-1:0] raddr_out,
    output logic [ADDRWIDTH-1:0] waddr_out,
    output logic                 we_out,
    input  logic [WIDTH-1:0]     rdata_in,
    output logic                 dump_valid,
    output logic [ADDRWIDTH-1:0] dump_addr,
    output logic [WIDTH-1:0]     dump_data,
    output logic                 busy,
    output logic                 done
);

    localparam logic [ADDRWIDTH-1:0] ADDR_MAX = '1;

    state_t               state, state_nx;
    logic [CNT_W-1:0]     remaining, remaining_nx;
    logic [ADDRWIDTH-1:0] last_addr;
    logic                 last_we;
    logic [ADDRWIDTH-1:0] drain_cnt;
    logic                 dump_valid_q;
    logic [ADDRWIDTH-1:0] dump_addr_q;
    logic                 hazard;
    logic                 accept;

    always_comb begin
        state_nx     = state;
        remaining_nx = remaining;
        bin_ready    = 1'b0;
        accept       = 1'b0;
        we_out       = 1'b0;
        raddr_out    = '0;
        hazard       = last_we && (bin_addr == last_addr);
        case (state)
            IDLE: begin
                if (start && !dump_valid_q) begin
                    remaining_nx = nsamp;
                    state_nx     = (nsamp != '0) ? ACCUM : FLUSH;
                end
            end
            ACCUM: begin
                bin_ready = !hazard;
                accept    = bin_valid && !hazard;
                we_out    = accept;
                raddr_out = accept ? bin_addr : last_addr;
                if (accept) begin
                    remaining_nx = remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1))
                        state_nx = FLUSH;
                end
            end
            FLUSH: begin
                raddr_out = last_addr;
                state_nx  = DRAIN;
            end
            DRAIN: begin
                raddr_out = drain_cnt;
                if (drain_cnt == ADDR_MAX)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // RAM writes back to the address it read, so both ports share one address
    assign waddr_out  = raddr_out;
    assign dump_valid = dump_valid_q;
    assign dump_addr  = dump_addr_q;
    assign dump_data  = rdata_in;
    assign done       = dump_valid_q && (dump_addr_q == ADDR_MAX);
    assign busy       = (state != IDLE) || dump_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            remaining    <= '0;
            last_addr    <= '0;
            last_we      <= 1'b0;
            drain_cnt    <= '0;
            dump_valid_q <= 1'b0;
            dump_addr_q  <= '0;
        end else begin
            state        <= state_nx;
            remaining    <= remaining_nx;
            last_we      <= accept;
            if (accept)
                last_addr <= bin_addr;
            dump_valid_q <= (state == DRAIN);
            dump_addr_q  <= drain_cnt;
            if (state == DRAIN)
                drain_cnt <= drain_cnt + ADDRWIDTH'(1);
            else
                drain_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_ram32m_hist_ctrl.sv
// Bench for ram32m_hist_ctrl: behavioural RAM attached, histogram reference
// built from the bins the bench offers.
module tb_ram32m_hist_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] nsamp = '0;
    logic        bin_valid = 1'b0;
    logic        bin_ready;
    logic [4:0]  bin_addr = '0;
    logic [4:0]  raddr_out, waddr_out;
    logic        we_out;
    logic [7:0]  rdata_in;
    logic        dump_valid;
    logic [4:0]  dump_addr;
    logic [7:0]  dump_data;
    logic        busy, done;

    logic [7:0]  mem [32];
    logic [7:0]  init_val [32];
    logic        do_load = 1'b0;
    logic [4:0]  waddr_q;
    logic        we_q;
    logic [7:0]  ref_h [32];
    logic [4:0]  bq [$];

    int err_cnt = 0;
    int chk_cnt = 0;

    ram32m_hist_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .nsamp(nsamp),
        .bin_valid(bin_valid), .bin_ready(bin_ready), .bin_addr(bin_addr),
        .raddr_out(raddr_out), .waddr_out(waddr_out), .we_out(we_out),
        .rdata_in(rdata_in), .dump_valid(dump_valid), .dump_addr(dump_addr),
        .dump_data(dump_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Distributed RAM: async read registered into rdata, registered write port
    always @(posedge clk) begin
        if (do_load) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_val[i];
            we_q <= 1'b0;
        end else begin
            rdata_in <= mem[raddr_out];
            waddr_q  <= waddr_out;
            we_q     <= we_out;
            if (we_q) mem[waddr_q] <= rdata_in + 8'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_run(input int n, input bit poke_accum, input bit poke_drain, input bit poke_last);
        int idx, cyc, exp_cyc, beat, waitc, dones;
        bit prev_acc;
        logic [4:0] prev_addr;
        exp_cyc = n;
        for (int i = 1; i < n; i++) if (bq[i] == bq[i-1]) exp_cyc++;
        @(negedge clk); #1;
        chk("idle_busy", busy, 0);
        start = 1'b1; nsamp = 16'(n);
        @(negedge clk);
        start = 1'b0;
        idx = 0; cyc = 0; prev_acc = 0; prev_addr = '0;
        while (idx < n && cyc < 3000) begin
            bin_valid = 1'b1; bin_addr = bq[idx];
            #1;
            chk("bin_ready", bin_ready, !(prev_acc && prev_addr == bq[idx]));
            if (bin_ready) begin
                chk("acc_we", we_out, 1);
                chk("acc_raddr", raddr_out, bq[idx]);
                chk("acc_waddr", waddr_out, bq[idx]);
                ref_h[bq[idx]] = ref_h[bq[idx]] + 8'd1;
                prev_acc = 1; prev_addr = bq[idx];
                idx++;
            end else begin
                chk("bubble_we", we_out, 0);
                prev_acc = 0;
            end
            if (poke_accum && cyc == 1) begin start = 1'b1; nsamp = 16'd7; end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        bin_valid = 1'b0;
        chk("acc_cycles", cyc, exp_cyc);
        #1;
        chk("flush_we", we_out, 0);
        chk("flush_ready", bin_ready, 0);
        chk("flush_busy", busy, 1);
        beat = 0; waitc = 0; dones = 0;
        while (beat < 32 && waitc < 80) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            waitc++;
            if (done) dones++;
            if (beat > 0 || dump_valid) begin
                chk("dump_valid", dump_valid, 1);
                chk("dump_addr", dump_addr, beat);
                chk("dump_data", dump_data, ref_h[beat]);
                chk("done_beat", done, beat == 31);
                chk("drain_ready", bin_ready, 0);
                if ((poke_drain && beat == 10) || (poke_last && beat == 31)) begin
                    start = 1'b1; nsamp = 16'd3;
                end
                beat++;
            end
        end
        chk("dump_beats", beat, 32);
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (done) dones++;
        end
        chk("done_count", dones, 1);
        chk("end_busy", busy, 0);
        chk("end_dump_valid", dump_valid, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            init_val[i] = 8'($urandom_range(0, 255));
            ref_h[i] = init_val[i];
        end
        do_load = 1'b1;
        repeat (2) @(negedge clk);
        do_load = 1'b0;
        #1;
        chk("rst_ready", bin_ready, 0);
        chk("rst_we", we_out, 0);
        chk("rst_raddr", raddr_out, 0);
        chk("rst_waddr", waddr_out, 0);
        chk("rst_dump_valid", dump_valid, 0);
        chk("rst_dump_addr", dump_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        bq = '{5'd5, 5'd6, 5'd7};
        do_run(3, 0, 0, 0);
        bq = '{5'd4, 5'd4, 5'd4};
        do_run(3, 0, 0, 0);
        bq.delete();
        do_run(0, 0, 0, 0);
        bq.delete();
        for (int i = 0; i < 256; i++) bq.push_back(5'd9);
        do_run(256, 0, 0, 0);

        bq.delete();
        for (int i = 0; i < 12; i++) bq.push_back(5'($urandom_range(0, 31)));
        do_run(12, 1, 1, 1);

        // reset in the middle of an accumulation, after its writes settled
        @(negedge clk);
        start = 1'b1; nsamp = 16'd5;
        @(negedge clk);
        start = 1'b0;
        bin_valid = 1'b1; bin_addr = 5'd3;
        #1;
        chk("mid_ready0", bin_ready, 1);
        ref_h[3] = ref_h[3] + 8'd1;
        @(negedge clk);
        bin_addr = 5'd20;
        #1;
        chk("mid_ready1", bin_ready, 1);
        ref_h[20] = ref_h[20] + 8'd1;
        @(negedge clk);
        bin_valid = 1'b0;
        repeat (2) @(negedge clk);
        bin_valid = 1'b1; bin_addr = 5'd3;
        #1;
        chk("mid_pre_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", bin_ready, 0);
        chk("mid_rst_we", we_out, 0);
        chk("mid_rst_raddr", raddr_out, 0);
        chk("mid_rst_waddr", waddr_out, 0);
        chk("mid_rst_dump_valid", dump_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_ready", bin_ready, 0);
        chk("post_rst_busy", busy, 0);
        bin_valid = 1'b0;
        bq.delete();
        do_run(0, 0, 0, 0);

        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(4, 40);
            bq.delete();
            bq.push_back(5'($urandom_range(0, 31)));
            for (int i = 1; i < n; i++) begin
                if ($urandom_range(0, 9) < 4) bq.push_back(bq[i-1]);
                else bq.push_back(5'($urandom_range(0, 31)));
            end
            do_run(n, 0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/ram32m_hist_ctrl.md
Name: ram32m_hist_ctrl

Overview:
Upstream sequencer for the 32-entry read-increment-write counter RAM (distributed RAM; registered write address/enable, combinational read address, registered read data, write data = read data + 1).
- Accepts a valid/ready stream of bin indices and issues one increment per accepted bin.
- Enforces the read-after-write hazard spacing the RAM requires.
- After a programmed number of samples, sweeps all entries and streams them out as a dump.

Parameters:
WIDTH, 8, counter/data width; matches RAM data width.
ADDRWIDTH, 5, bin address width; depth = 2**ADDRWIDTH.
CNT_W, 16, width of the sample-count register.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
start  in  1  single-cycle pulse; begins a run (honoured only in IDLE).
nsamp  in  CNT_W  samples to accept in this run; sampled when start is honoured.
bin_valid  in  1  bin stream valid.
bin_ready  out  1  bin stream ready.
bin_addr  in  ADDRWIDTH  bin index to increment.
raddr_out  out  ADDRWIDTH  to RAM read address (combinational into RAM).
waddr_out  out  ADDRWIDTH  to RAM write address input.
we_out  out  1  to RAM write-enable input.
rdata_in  in  WIDTH  from RAM registered read data.
dump_valid  out  1  dump beat valid; no backpressure.
dump_addr  out  ADDRWIDTH  bin index of dump beat.
dump_data  out  WIDTH  count of that bin.
busy  out  1  high whenever state != IDLE or a dump beat is pending.
done  out  1  one-cycle pulse coincident with the final dump beat.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, remaining=0, last_we=0, drain counter=0.
  - Outputs: bin_ready=0, we_out=0, raddr_out=waddr_out=0, dump_valid=0, dump_addr=0, busy=0, done=0.
- FSM states: IDLE, ACCUM, FLUSH, DRAIN.
- IDLE:
  - start=1: remaining<=nsamp; go to ACCUM if nsamp!=0, else go to FLUSH.
- ACCUM:
  - hazard = last_we && (bin_addr == last_addr), where last_addr and last_we are registered from the previous cycle's accept.
  - bin_ready = !hazard (combinational).
  - Accept = bin_valid && bin_ready. On accept, combinationally: raddr_out=waddr_out=bin_addr, we_out=1.
  - Without an accept: we_out=0 and raddr_out holds last_addr.
  - Timing rationale: an accept in cycle t lands in the RAM at the end of cycle t+1. The same address may be accepted again in cycle t+2 at the earliest, so exactly one bubble is inserted. Different addresses run back-to-back.
  - Each accept decrements remaining. An accept with remaining==1 moves to FLUSH.
- FLUSH: exactly 1 cycle with we_out=0, so the last write commits; then go to DRAIN with drain counter=0.
- DRAIN:
  - raddr_out = drain counter, we_out=0, bin_ready=0; counter increments 0..2**ADDRWIDTH-1.
  - Last address issued: go to IDLE.
  - dump_valid and dump_addr are the registered (1-cycle delayed) issue flag and address; dump_data = rdata_in (combinational).
  - First dump beat appears the cycle after the first read. Exactly 2**ADDRWIDTH beats, contiguous.
  - done=1 on the beat with dump_addr = all-ones.
- Ignored inputs:
  - start outside IDLE is ignored, including while the last dump beat is pending.
  - bin_valid outside ACCUM is ignored; no accept occurs.
- Counts wrap modulo 2**WIDTH (RAM arithmetic).
- The RAM has no clear: histograms accumulate across runs. Consumers difference successive dumps.
- Reset mid-run: FSM returns to IDLE at once and we_out drops. One write already registered inside the RAM may still complete; this is permitted.

Decomposition:
- Package hist_pkg holds:
  - state enum type (IDLE, ACCUM, FLUSH, DRAIN);
  - default widths (WIDTH=8, ADDRWIDTH=5, CNT_W=16);
  - FLUSH_CYCLES=1.
- No sub-module required. The hazard compare and the drain address generator stay inline.

Test Plan:
- Reset asserted mid-ACCUM -> all outputs 0 in the same cycle; after release, state IDLE, bin_ready=0.
- start nsamp=3, bins 5,6,7 held valid -> bin_ready=1 for 3 consecutive cycles; 1 FLUSH cycle; 32 dump beats. Bins 5,6,7 show prior+1; all other bins unchanged; done on beat 31.
- start nsamp=3, bin 4 held valid continuously -> bin_ready pattern 1,0,1,0,1; dump shows bin4 = prior+3.
- start nsamp=0 -> no accepts; FLUSH then DRAIN; 32 beats equal prior contents; exactly one done pulse.
- nsamp=256, bin 9 every cycle, WIDTH=8 -> 256 accepts over 511 cycles; dump bin9 equals its pre-run value (wrap).
- Pulse start during ACCUM and during DRAIN -> ignored; remaining count and dump sequence unaffected.
